guess_grader: RTL

//  Sequential Mastermind scorer. Latches a 4-peg guess and the master pattern on start.

---
 rtl/mastermind_pkg.sv | 26 ++
 rtl/color_counter.sv | 24 ++
 rtl/guess_grader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared Mastermind grading types and constants
package mastermind_pkg;

  localparam int NUM_PEGS   = 4;
  localparam int NUM_COLORS = 6;
  localparam int COLOR_W    = 3;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 3;

  typedef logic [COLOR_W-1:0] peg_t;
  typedef peg_t [NUM_PEGS-1:0] pattern_t;

  typedef enum logic [1:0] {
    IDLE,
    RED,
    COLOR,
    DONE
  } grade_state_t;

  // Smaller of two per-colour counts: pegs of that colour that can pair up.
  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/color_counter.sv
// rtl/color_counter.sv - combinational count of pegs matching one colour
module color_counter
  import mastermind_pkg::*;
(
  input  pattern_t         i_pattern,
  input  peg_t             i_color,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] w_count;

  // Walk every peg and tally the ones equal to the requested colour.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (i_pattern[i] == i_color) begin
        w_count = w_count + CNT_W'(1);
      end
    end
  end

  assign o_count = w_count;

endmodule

// File: rtl/guess_grader.sv
// rtl/guess_grader.sv - sequential Mastermind red/white peg scorer
module guess_grader
  import mastermind_pkg::*;
(
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [NUM_PEGS*COLOR_W-1:0]   i_guess,
  input  logic [NUM_PEGS*COLOR_W-1:0]   i_master,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [CNT_W-1:0]              o_red,
  output logic [CNT_W-1:0]              o_white,
  output logic                          o_error
);

  localparam logic [IDX_W-1:0] LAST_PEG   = IDX_W'(NUM_PEGS - 1);
  localparam logic [IDX_W-1:0] LAST_COLOR = IDX_W'(NUM_COLORS - 1);
  localparam peg_t             MAX_COLOR  = peg_t'(NUM_COLORS);

  grade_state_t     r_state;
  logic [IDX_W-1:0] r_idx;
  pattern_t         r_g;
  pattern_t         r_m;
  logic [CNT_W-1:0] r_acc_red;
  logic [CNT_W-1:0] r_acc_match;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_red;
  logic [CNT_W-1:0] r_white;
  logic             r_error;

  logic [CNT_W-1:0] w_g_cnt;
  logic [CNT_W-1:0] w_m_cnt;
  logic [CNT_W-1:0] w_match_next;
  logic             w_peg_eq;
  logic             w_error;

  // The index doubles as the colour under test while in COLOR.
  color_counter u_g_counter (
    .i_pattern (r_g),
    .i_color   (peg_t'(r_idx)),
    .o_count   (w_g_cnt)
  );

  color_counter u_m_counter (
    .i_pattern (r_m),
    .i_color   (peg_t'(r_idx)),
    .o_count   (w_m_cnt)
  );

  assign w_peg_eq     = (r_g[r_idx[1:0]] == r_m[r_idx[1:0]]);
  assign w_match_next = r_acc_match + min_cnt(w_g_cnt, w_m_cnt);

  // Flag any latched peg outside the legal colour range in either pattern.
  always_comb begin
    w_error = 1'b0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if ((r_g[i] >= MAX_COLOR) || (r_m[i] >= MAX_COLOR)) begin
        w_error = 1'b1;
      end
    end
  end

  // Grading FSM: latch operands, scan pegs for reds, scan colours for total matches, report.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_g         <= '0;
      r_m         <= '0;
      r_acc_red   <= '0;
      r_acc_match <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_red       <= '0;
      r_white     <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_g         <= i_guess;
            r_m         <= i_master;
            r_acc_red   <= '0;
            r_acc_match <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= RED;
          end
        end
        RED: begin
          r_acc_red <= r_acc_red + CNT_W'(w_peg_eq);
          if (r_idx == LAST_PEG) begin
            r_idx   <= '0;
            r_state <= COLOR;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        COLOR: begin
          r_acc_match <= w_match_next;
          if (r_idx == LAST_COLOR) begin
            // Results use the final colour's contribution directly, so DONE needs no extra cycle.
            r_done  <= 1'b1;
            r_state <= DONE;
            if (w_error) begin
              r_red   <= '0;
              r_white <= '0;
              r_error <= 1'b1;
            end else begin
              r_red   <= r_acc_red;
              r_white <= w_match_next - r_acc_red;
              r_error <= 1'b0;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_red   = r_red;
  assign o_white = r_white;
  assign o_error = r_error;

endmodule
